// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
// Forwarding select encodings and controller FSM states.
// Imported by pipeline_ctrl and forwarding_unit.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/forwarding_unit.sv
// Operand forwarding select for one E-stage source register.
// Latency: combinational, zero cycles.
// Backpressure: none; independent of stalls and flushes.
module forwarding_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_e_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
  input  logic                      reg_write_m_i,
  input  logic                      reg_write_w_i,
  output fwd_sel_t                  fwd_o
);

  // M holds the younger result, so it wins over W; x0 is never forwarded.
  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
      fwd_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and memory-wait sequencing for the 5-stage core.
// Latency: enables/flushes/forwards combinational; state, MemErr, counters registered.
// Backpressure: memory not-ready freezes F..M and bubbles W; timeout halts permanently.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32,
  parameter int MEM_TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic                      ResultSrcE0,
  input  logic                      PCSrcE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      ReqM,
  input  logic                      ReadyM,
  output logic                      EnF,
  output logic                      EnD,
  output logic                      EnE,
  output logic                      EnM,
  output logic                      EnW,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      MemErr,
  output logic [CNT_WIDTH-1:0]      StallCycles,
  output logic [CNT_WIDTH-1:0]      FlushCycles
);

  localparam int WW = $clog2(MEM_TIMEOUT) + 1;

  ctrl_state_t          state_q;
  logic [WW-1:0]        wait_q;
  logic                 mem_err_q;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;
  fwd_sel_t             fwd_a, fwd_b;
  logic                 lw_stall, mem_stall;

  forwarding_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_e_i        (Rs1E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (fwd_a)
  );

  forwarding_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_e_i        (Rs2E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (fwd_b)
  );

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

  assign lw_stall  = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_stall = ReqM && !ReadyM;

  // Enable/flush priority: HALT > memory wait > taken branch > load-use > run.
  always_comb begin
    EnF = 1'b1; EnD = 1'b1; EnE = 1'b1; EnM = 1'b1; EnW = 1'b1;
    FlushD = 1'b0; FlushE = 1'b0; FlushW = 1'b0;
    if (state_q == HALT) begin
      EnF = 1'b0; EnD = 1'b0; EnE = 1'b0; EnM = 1'b0; EnW = 1'b0;
    end else if (mem_stall) begin
      // Freeze F..M; a held branch flushes only once the access completes.
      EnF = 1'b0; EnD = 1'b0; EnE = 1'b0; EnM = 1'b0;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      // Squashing D also removes any load-use dependent sitting there.
      FlushD = 1'b1; FlushE = 1'b1;
    end else if (lw_stall) begin
      EnF = 1'b0; EnD = 1'b0;
      FlushE = 1'b1;
    end
  end

  // Memory wait sequencing with timeout; HALT is left only through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_stall) begin
            state_q <= MEM_WAIT;
            wait_q  <= WW'(1);
          end
        end
        MEM_WAIT: begin
          if (!mem_stall) begin
            // Completion, or a dropped request, both release the freeze.
            state_q <= RUN;
            wait_q  <= '0;
          end else if (wait_q == WW'(MEM_TIMEOUT - 1)) begin
            state_q   <= HALT;
            mem_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end

  assign MemErr = mem_err_q;

  // Saturating next values for the performance counters.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!EnF && (stall_q != '1)) stall_d = stall_q + CNT_WIDTH'(1);
    if ((FlushD || FlushE) && (flush_q != '1)) flush_d = flush_q + CNT_WIDTH'(1);
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign StallCycles = stall_q;
  assign FlushCycles = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (CNT_WIDTH=4, MEM_TIMEOUT=4).
// Expected outputs are queued when stimulus is applied and popped at sample time.
// Counters are tracked by a small saturating model driven from the expected enables.
module tb_pipeline_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [RW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, ReqM, ReadyM;
  logic EnF, EnD, EnE, EnM, EnW, FlushD, FlushE, FlushW, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] StallCycles, FlushCycles;

  typedef struct {
    logic [4:0] en;
    logic [2:0] fl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
    int         stall;
    int         flush;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int m_stall = 0;
  int m_flush = 0;

  pipeline_ctrl #(.REG_ADDR_WIDTH(RW), .CNT_WIDTH(CW), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ReqM(ReqM), .ReadyM(ReadyM),
    .EnF(EnF), .EnD(EnD), .EnE(EnE), .EnM(EnM), .EnW(EnW),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCycles(StallCycles), .FlushCycles(FlushCycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE0 = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    ReqM = 1'b0; ReadyM = 1'b0;
  endtask

  // Inputs are already applied (just after a falling edge). Queue the expectation,
  // compare before the rising edge, then advance the counter model across it.
  task automatic step(input string tag, input logic [4:0] en, input logic [2:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb, input logic err);
    exp_t e;
    e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.err = err;
    e.stall = m_stall; e.flush = m_flush;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    chk({tag, ".en"},    {27'd0, EnF, EnD, EnE, EnM, EnW}, {27'd0, e.en});
    chk({tag, ".flush"}, {29'd0, FlushD, FlushE, FlushW},  {29'd0, e.fl});
    chk({tag, ".fwd"},   {28'd0, ForwardAE, ForwardBE},    {28'd0, e.fa, e.fb});
    chk({tag, ".err"},   {31'd0, MemErr},                  {31'd0, e.err});
    chk({tag, ".scnt"},  {28'd0, StallCycles},             e.stall);
    chk({tag, ".fcnt"},  {28'd0, FlushCycles},             e.flush);
    @(posedge clk);
    if (!e.en[4] && m_stall < SAT) m_stall++;
    if ((e.fl[2] || e.fl[1]) && m_flush < SAT) m_flush++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    // Reset state while rst is held
    step("reset", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
    rst = 1'b0;

    // Forwarding, operand A: M over W, then W, then register file
    Rs1E = 5'd5; RdM = 5'd5; RdW = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
    step("fwdA_M", 5'b11111, 3'b000, 2'b10, 2'b00, 1'b0);
    RdM = 5'd0;
    step("fwdA_W", 5'b11111, 3'b000, 2'b01, 2'b00, 1'b0);
    RdW = 5'd0;
    step("fwdA_RF", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
    // Operand B, plus a match in M with RegWriteM off falling through to W
    idle(); Rs2E = 5'd6; RdM = 5'd6; RdW = 5'd6; RegWriteM = 1'b1; RegWriteW = 1'b1;
    step("fwdB_M", 5'b11111, 3'b000, 2'b00, 2'b10, 1'b0);
    RegWriteM = 1'b0;
    step("fwdB_W", 5'b11111, 3'b000, 2'b00, 2'b01, 1'b0);
    RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1;
    step("fwdB_RF", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);

    // Load-use stall, then RdE=0 never stalls
    idle(); ResultSrcE0 = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    step("lwstall", 5'b00111, 3'b010, 2'b00, 2'b00, 1'b0);
    RdE = 5'd0; Rs2D = 5'd0;
    step("lw_rd0", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);

    // Branch together with load-use: branch wins, no stall
    idle(); ResultSrcE0 = 1'b1; RdE = 5'd7; Rs1D = 5'd7; PCSrcE = 1'b1;
    step("br_lw", 5'b11111, 3'b110, 2'b00, 2'b00, 1'b0);

    // Memory wait of 3 cycles with a branch held in E
    idle();
    do_reset();
    ReqM = 1'b1; ReadyM = 1'b0; PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) step("memwait", 5'b00001, 3'b001, 2'b00, 2'b00, 1'b0);
    ReadyM = 1'b1;
    step("memrel", 5'b11111, 3'b110, 2'b00, 2'b00, 1'b0);
    idle();
    step("memafter", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
    chk("memwait.stall3", {28'd0, StallCycles}, 32'd3);

    // Dropping ReqM mid-wait releases and restarts the timeout count
    ReqM = 1'b1;
    step("drop_w", 5'b00001, 3'b001, 2'b00, 2'b00, 1'b0);
    ReqM = 1'b0;
    step("drop_rel", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);
    ReqM = 1'b1;
    for (int i = 0; i < 3; i++) step("drop_re", 5'b00001, 3'b001, 2'b00, 2'b00, 1'b0);
    ReadyM = 1'b1;
    step("drop_ok", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);

    // Timeout: four not-ready cycles, then permanent halt
    idle(); ReqM = 1'b1;
    for (int i = 0; i < 4; i++) step("to_wait", 5'b00001, 3'b001, 2'b00, 2'b00, 1'b0);
    step("halt", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b1);
    ReadyM = 1'b1; PCSrcE = 1'b1;
    for (int i = 0; i < 2; i++) step("halt_rdy", 5'b00000, 3'b000, 2'b00, 2'b00, 1'b1);

    // Asynchronous reset mid-cycle clears everything before the next edge
    rst = 1'b1;
    #1;
    chk("arst.err",  {31'd0, MemErr}, 32'd0);
    chk("arst.scnt", {28'd0, StallCycles}, 32'd0);
    chk("arst.fcnt", {28'd0, FlushCycles}, 32'd0);
    chk("arst.en",   {27'd0, EnF, EnD, EnE, EnM, EnW}, 32'h1F);
    rst = 1'b0;
    m_stall = 0;
    m_flush = 0;
    idle();
    @(negedge clk);
    step("post_rst", 5'b11111, 3'b000, 2'b00, 2'b00, 1'b0);

    // Saturation: 20 cycles of load-use stall on 4-bit counters
    ResultSrcE0 = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
    for (int i = 0; i < 20; i++) step("sat", 5'b00111, 3'b010, 2'b00, 2'b00, 1'b0);
    chk("sat.stall", {28'd0, StallCycles}, 32'd15);
    chk("sat.flush", {28'd0, FlushCycles}, 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
